// File: rtl/fsm_sequence_gen.sv
// Serial bit-sequence generator.
// It latches a parallel pattern on start and shifts it out MSB-first on w, one bit per clock.
// The frame can repeat back-to-back. The block then gives a one-cycle done pulse and returns
// to idle.
module fsm_sequence_gen #(
  parameter int unsigned MAX_LEN    = 8,
  parameter int unsigned LEN_W      = 4,
  parameter int unsigned REP_W      = 3,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   length,
  input  logic [REP_W-1:0]   repeat_n,
  output logic               w,
  output logic               valid,
  output logic               busy,
  output logic               done
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [LEN_W-1:0] MaxLenW = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [IDX_W-1:0]   last_q, last_d;   // index of the first (MSB) bit of a frame
  logic [REP_W-1:0]   rep_q, rep_d;     // repetitions still owed after the current one
  logic [IDX_W-1:0]   idx_q, idx_d;     // index of the bit currently on w
  logic               w_q, w_d;

  logic [LEN_W-1:0]   len_clamp;
  logic [LEN_W-1:0]   len_m1;
  logic [IDX_W-1:0]   first_idx;
  logic [IDX_W-1:0]   idx_dec;

  // Operand decode for acceptance: clamp oversize lengths, derive first bit index.
  always_comb begin
    len_clamp = (length > MaxLenW) ? MaxLenW : length;
    len_m1    = len_clamp - 1'b1;
    first_idx = len_m1[IDX_W-1:0];
    idx_dec   = idx_q - 1'b1;
  end

  // Next-state logic; w is computed one step ahead so the output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    last_d  = last_q;
    rep_d   = rep_q;
    idx_d   = idx_q;
    w_d     = w_q;
    unique case (state_q)
      StIdle: begin
        w_d = IDLE_LEVEL;
        if (start) begin
          pat_d  = pattern;
          last_d = first_idx;
          rep_d  = repeat_n;
          if (len_clamp == '0) begin
            state_d = StDone;
          end else begin
            state_d = StSend;
            idx_d   = first_idx;
            w_d     = pattern[first_idx];
          end
        end
      end
      StSend: begin
        if (idx_q != '0) begin
          idx_d = idx_dec;
          w_d   = pat_q[idx_dec];
        end else if (rep_q != '0) begin
          // Restart the frame with no gap cycle.
          rep_d = rep_q - 1'b1;
          idx_d = last_q;
          w_d   = pat_q[last_q];
        end else begin
          state_d = StDone;
          w_d     = IDLE_LEVEL;
        end
      end
      StDone: begin
        state_d = StIdle;
        w_d     = IDLE_LEVEL;
      end
      default: begin
        state_d = StIdle;
        w_d     = IDLE_LEVEL;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      pat_q   <= '0;
      last_q  <= '0;
      rep_q   <= '0;
      idx_q   <= '0;
      w_q     <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      last_q  <= last_d;
      rep_q   <= rep_d;
      idx_q   <= idx_d;
      w_q     <= w_d;
    end
  end

  // Outputs decode registered state only, so start has no combinational path to them.
  always_comb begin
    w     = w_q;
    valid = (state_q == StSend);
    busy  = (state_q == StSend);
    done  = (state_q == StDone);
  end

endmodule

// File: tb/tb_fsm_sequence_gen.sv
// Scoreboard bench for fsm_sequence_gen.
// Each expected output cycle, packed as {w, valid, busy, done}, is queued when a frame is
// requested. Entries are popped one per clock after the active edge; an empty queue means idle.
module tb_fsm_sequence_gen;

  logic       clock;
  logic       reset;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] length;
  logic [2:0] repeat_n;
  logic       w, valid, busy, done;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [3:0]  exp_q[$];

  fsm_sequence_gen #(
    .MAX_LEN   (8),
    .LEN_W     (4),
    .REP_W     (3),
    .IDLE_LEVEL(1'b0)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .length  (length),
    .repeat_n(repeat_n),
    .w       (w),
    .valid   (valid),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {w,valid,busy,done}=%b, expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // Queue the cycles a frame should produce: every bit with valid/busy, then one done cycle.
  task automatic push_frame(input logic [7:0] pat, input int len, input int rep);
    int le;
    le = (len > 8) ? 8 : len;
    for (int r = 0; r <= rep; r++) begin
      for (int i = le - 1; i >= 0; i--) begin
        exp_q.push_back({pat[i], 1'b1, 1'b1, 1'b0});
      end
    end
    exp_q.push_back(4'b0001);
  endtask

  // Advance one clock and compare outputs just after the edge.
  task automatic tick(input string tag);
    logic [3:0] e;
    @(posedge clock);
    #1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 4'b0000;
    check_eq(tag, {w, valid, busy, done}, e);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      tick(tag);
      guard++;
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] pat, input logic [3:0] len,
                           input logic [2:0] rep);
    pattern  = pat;
    length   = len;
    repeat_n = rep;
    start    = 1'b1;
    push_frame(pat, int'(len), int'(rep));
    tick(tag);
    start = 1'b0;
    drain(tag);
    tick({tag, "_idle"});
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    pattern  = '0;
    length   = '0;
    repeat_n = '0;
    #1;
    check_eq("reset_t0", {w, valid, busy, done}, 4'b0000);
    repeat (2) @(posedge clock);
    #1;
    check_eq("reset_held", {w, valid, busy, done}, 4'b0000);
    reset = 1'b1;
    tick("idle_after_reset");

    // Basic frame and a repeated frame with no gap.
    run_frame("t1_len3", 8'b0000_0010, 4'd3, 3'd0);
    run_frame("t2_rep1", 8'b0001_1100, 4'd5, 3'd1);

    // Width corner cases: empty, clamped, single bit, max repeats.
    run_frame("t3_len0", 8'hA5, 4'd0, 3'd2);
    run_frame("t3_len12", 8'hA5, 4'd12, 3'd0);
    run_frame("t3_len1", 8'h01, 4'd1, 3'd0);
    run_frame("t3_len8_rep7", 8'h96, 4'd8, 3'd7);

    // Operand changes and a start pulse mid-frame must not disturb the current frame.
    pattern  = 8'b0000_1011;
    length   = 4'd4;
    repeat_n = 3'd0;
    start    = 1'b1;
    push_frame(8'b0000_1011, 4, 0);
    tick("t4_start");
    pattern  = 8'hF0;
    length   = 4'd2;
    repeat_n = 3'd3;
    tick("t4_mid");
    start = 1'b0;
    drain("t4_rest");
    tick("t4_idle");
    tick("t4_idle2");

    // Asynchronous reset during bit 2 of a 4-bit frame.
    pattern  = 8'h0F;
    length   = 4'd4;
    repeat_n = 3'd0;
    start    = 1'b1;
    push_frame(8'h0F, 4, 0);
    tick("t5_bit1");
    start = 1'b0;
    tick("t5_bit2");
    #2;
    reset = 1'b0;
    #1;
    check_eq("t5_async_clear", {w, valid, busy, done}, 4'b0000);
    exp_q.delete();
    @(posedge clock);
    #1;
    check_eq("t5_reset_held", {w, valid, busy, done}, 4'b0000);
    reset = 1'b1;
    tick("t5_no_done");
    run_frame("t5_full", 8'h0F, 4'd4, 3'd0);

    // start held high: frames separated by the done cycle and one idle cycle.
    pattern  = 8'b0000_0011;
    length   = 4'd2;
    repeat_n = 3'd0;
    start    = 1'b1;
    push_frame(8'b11, 2, 0);
    exp_q.push_back(4'b0000);
    push_frame(8'b11, 2, 0);
    exp_q.push_back(4'b0000);
    push_frame(8'b11, 2, 0);
    drain("t6_hold");
    start = 1'b0;
    tick("t6_idle");
    tick("t6_idle2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
